// File: rtl/btn_event_reader.sv
`default_nettype none
// ============================================================================
//  Module   : btn_event_reader
//  Purpose  : Synchronise and debounce 8 raw buttons, publish debounced levels
//             and queue press/release events in a small valid/ready FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_event_reader #(
    parameter int DEBOUNCE_CYCLES = 2000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] btn_raw,
    output logic [7:0] btn_state,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_data,
    output logic       evt_overflow,
    input  logic       clr_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   c_depth   = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       r_s1;
    logic [7:0]       r_s2;
    logic [7:0]       w_toggle;
    logic [7:0]       r_pend;
    logic [7:0]       r_ptype;
    logic [2:0]       w_sel;
    logic             w_pend_any;
    logic             w_pop;
    logic             w_can_push;
    logic             w_push;
    logic [3:0]       w_push_data;
    logic [7:0]       w_push_mask;
    logic             w_lost;
    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_nxt;
    logic [PTR_W:0]   w_after_pop;
    logic [3:0]       w_head_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= btn_raw;
            r_s2 <= r_s1;
        end
    end

    // Counter runs only while the synchronised level disagrees with btn_state
    for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if ((r_s2[gi] == btn_state[gi]) || (r_cnt == c_cnt_max)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_toggle[gi] = (r_s2[gi] != btn_state[gi]) && (r_cnt == c_cnt_max);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_state <= '0;
        end else begin
            btn_state <= btn_state ^ w_toggle;
        end
    end

    // Lowest pending index wins
    always_comb begin
        w_sel      = '0;
        w_pend_any = |r_pend;
        for (int i = 7; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    assign w_pop       = evt_valid && evt_ready;
    assign w_can_push  = (r_count != c_depth) || w_pop;
    assign w_push      = w_pend_any && w_can_push;
    assign w_push_data = {r_ptype[w_sel], w_sel};
    assign w_push_mask = w_push ? (8'd1 << w_sel) : 8'd0;
    assign w_lost      = |(w_toggle & r_pend & ~w_push_mask);

    // A toggle on the index being pushed re-arms pending with the new level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend       <= '0;
            r_ptype      <= '0;
            evt_overflow <= 1'b0;
        end else begin
            r_pend  <= (r_pend & ~w_push_mask) | w_toggle;
            r_ptype <= (r_ptype & ~w_toggle) | (~btn_state & w_toggle);
            if (w_lost) begin
                evt_overflow <= 1'b1;
            end else if (clr_overflow) begin
                evt_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    assign w_count_nxt = r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
    assign w_after_pop = r_count - (PTR_W + 1)'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);

    // Head is precomputed so evt_data can be registered; bypass when pushing into an emptying FIFO
    always_comb begin
        w_head_nxt = '0;
        if (w_count_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_after_pop == '0) begin
            w_head_nxt = w_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            evt_valid <= 1'b0;
            evt_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_count   <= w_count_nxt;
            evt_valid <= (w_count_nxt != '0);
            evt_data  <= w_head_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_event_reader
//  Purpose  : Directed and randomised checks of btn_event_reader against a
//             queue-based event model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_btn_event_reader;

    localparam int DC = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] btn_raw = '0;
    logic [7:0] btn_state;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [3:0] evt_data;
    logic       evt_overflow;
    logic       clr_overflow = 1'b0;

    btn_event_reader #(
        .DEBOUNCE_CYCLES(DC),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .evt_overflow(evt_overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw sample history, debounced levels, pending events, FIFO queue
    logic [7:0] hist [$];
    logic [7:0] m_state = '0;
    logic [7:0] m_pend  = '0;
    logic [7:0] m_ptype = '0;
    logic [3:0] m_q [$];
    logic       m_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Level seen by the debouncer j edges before the current one (two-flop delay)
    function automatic logic [7:0] seen(input int j);
        if (hist.size() > j + 1) return hist[j + 1];
        return 8'h00;
    endfunction

    task automatic check_model();
        check("btn_state", 32'(btn_state), 32'(m_state));
        check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        check("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
        check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
    endtask

    // Called at a negedge; drives inputs, advances the model by one edge, checks, ends at next negedge
    task automatic tick(input logic [7:0] raw, input logic rdy, input logic clr);
        logic [7:0] tg;
        logic [7:0] pushed;
        logic [7:0] s;
        logic       pop;
        logic       push;
        int         idx;
        btn_raw      = raw;
        evt_ready    = rdy;
        clr_overflow = clr;
        pop = (m_q.size() > 0) && rdy;
        for (int i = 0; i < 8; i++) begin
            tg[i] = 1'b1;
            for (int j = 0; j < DC; j++) begin
                s = seen(j);
                if (s[i] == m_state[i]) tg[i] = 1'b0;
            end
        end
        idx = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i]) idx = i;
        end
        push   = (idx >= 0) && ((m_q.size() < FD) || pop);
        pushed = '0;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back({m_ptype[idx], idx[2:0]});
            pushed[idx] = 1'b1;
        end
        if (|(tg & m_pend & ~pushed)) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_pend  = (m_pend & ~pushed) | tg;
        m_ptype = (m_ptype & ~tg) | (~m_state & tg);
        m_state = m_state ^ tg;
        hist.push_front(raw);
        if (hist.size() > DC + 2) void'(hist.pop_back());
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [7:0] raw);
        #2 rstn = 1'b0;
        #1;
        check("rst_btn_state", 32'(btn_state), 32'h0);
        check("rst_evt_valid", 32'(evt_valid), 32'h0);
        check("rst_evt_data", 32'(evt_data), 32'h0);
        check("rst_evt_overflow", 32'(evt_overflow), 32'h0);
        m_state = '0;
        m_pend  = '0;
        m_ptype = '0;
        m_ovf   = 1'b0;
        m_q.delete();
        hist.delete();
        @(negedge clk);
        btn_raw = raw;
        rstn    = 1'b1;
    endtask

    initial begin
        logic [7:0] cur;
        logic       rdy;
        logic [3:0] exp_drain [4];
        exp_drain = '{4'h0, 4'h9, 4'h1, 4'h1};

        repeat (3) @(negedge clk);
        check("init_btn_state", 32'(btn_state), 32'h0);
        check("init_evt_valid", 32'(evt_valid), 32'h0);
        check("init_evt_data", 32'(evt_data), 32'h0);
        check("init_evt_overflow", 32'(evt_overflow), 32'h0);
        rstn = 1'b1;

        // Clean press of button 3
        for (int k = 0; k < 7; k++) begin
            tick(8'h08, 1'b0, 1'b0);
            if (k == 4) check("press_state_e4", 32'(btn_state), 32'h00);
            if (k == 5) begin
                check("press_state_e5", 32'(btn_state), 32'h08);
                check("press_valid_e5", 32'(evt_valid), 32'h0);
            end
            if (k == 6) begin
                check("press_valid_e6", 32'(evt_valid), 32'h1);
                check("press_data_e6", 32'(evt_data), 32'hB);
            end
        end
        tick(8'h08, 1'b1, 1'b0);
        check("press_popped", 32'(evt_valid), 32'h0);
        repeat (8) tick(8'h00, 1'b1, 1'b0);

        // Glitch rejection, then a pulse long enough to register
        repeat (3) tick(8'h01, 1'b0, 1'b0);
        repeat (8) tick(8'h00, 1'b0, 1'b0);
        check("glitch3_state", 32'(btn_state), 32'h0);
        check("glitch3_valid", 32'(evt_valid), 32'h0);
        repeat (6) tick(8'h01, 1'b0, 1'b0);
        repeat (10) tick(8'h00, 1'b0, 1'b0);
        check("pulse6_head", 32'(evt_data), 32'h8);
        tick(8'h00, 1'b1, 1'b0);
        check("pulse6_second", 32'(evt_data), 32'h0);
        check("pulse6_second_valid", 32'(evt_valid), 32'h1);
        tick(8'h00, 1'b1, 1'b0);
        check("pulse6_empty", 32'(evt_valid), 32'h0);

        // Simultaneous edges on buttons 0, 2, 7 with a ready consumer
        for (int k = 0; k < 10; k++) begin
            tick(8'h85, 1'b1, 1'b0);
            if (k == 5) check("simul_state", 32'(btn_state), 32'h85);
            if (k == 6) check("simul_evt0", 32'(evt_data), 32'h8);
            if (k == 7) check("simul_evt1", 32'(evt_data), 32'hA);
            if (k == 8) check("simul_evt2", 32'(evt_data), 32'hF);
            if (k == 9) check("simul_empty", 32'(evt_valid), 32'h0);
        end
        repeat (10) tick(8'h00, 1'b1, 1'b0);

        // Fill the FIFO, then lose an event on button 1
        repeat (7) tick(8'h01, 1'b0, 1'b0);
        repeat (7) tick(8'h00, 1'b0, 1'b0);
        repeat (7) tick(8'h02, 1'b0, 1'b0);
        repeat (7) tick(8'h00, 1'b0, 1'b0);
        repeat (7) tick(8'h02, 1'b0, 1'b0);
        check("full_no_ovf_yet", 32'(evt_overflow), 32'h0);
        repeat (7) tick(8'h00, 1'b0, 1'b0);
        check("ovf_set", 32'(evt_overflow), 32'h1);
        check("full_head", 32'(evt_data), 32'h8);
        for (int k = 0; k < 4; k++) begin
            tick(8'h00, 1'b1, 1'b0);
            check("drain_order", 32'(evt_data), 32'(exp_drain[k]));
        end
        tick(8'h00, 1'b1, 1'b0);
        check("drain_empty", 32'(evt_valid), 32'h0);
        check("ovf_sticky", 32'(evt_overflow), 32'h1);
        tick(8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(evt_overflow), 32'h0);

        // Reset in the middle of a debounce
        repeat (7) tick(8'h08, 1'b0, 1'b0);
        repeat (4) tick(8'h28, 1'b0, 1'b0);
        apply_reset(8'h20);
        for (int k = 0; k < 7; k++) begin
            tick(8'h20, 1'b0, 1'b0);
            if (k == 5) begin
                check("postrst_state", 32'(btn_state), 32'h20);
                check("postrst_valid_e5", 32'(evt_valid), 32'h0);
            end
            if (k == 6) check("postrst_data", 32'(evt_data), 32'hD);
        end
        tick(8'h20, 1'b1, 1'b0);

        // Random traffic with alternating consumer pressure
        cur = 8'h20;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, 7)] ^= 1'b1;
            if (((n / 400) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            tick(cur, rdy, $urandom_range(0, 40) == 0);
            if (n == 1700) apply_reset(cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
